// File: rtl/muldiv_unit_pkg.sv
// Shared CPU constants for the M-extension unit: FUNC3 op encodings, FSM states
// and the sign/selection step that turns raw magnitudes into the final RESULT.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [4:0] CNT_LOAD = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // hi/lo hold either the unsigned 64-bit product or {remainder, quotient}.
  function automatic logic [31:0] mdu_finalize(input logic [2:0]  f3,
                                               input logic        neg_a,
                                               input logic        neg_b,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo);
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res;
    prod = {hi, lo};
    if (neg_a ^ neg_b) prod = -prod;
    quot = (neg_a ^ neg_b) ? -lo : lo;
    rem  = neg_a ? -hi : hi;
    case (f3)
      F3_MUL:          res = prod[31:0];
      F3_DIV, F3_DIVU: res = quot;
      F3_REM, F3_REMU: res = rem;
      default:         res = prod[63:32];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle. START is a request sampled
// only in IDLE; DONE is a one-cycle pulse qualifying RESULT and WRITE_ADDR_OUT.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        START;
  logic [2:0]  FUNC3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic [4:0]  WRITE_ADDR_IN;
  logic        FLUSH;
  logic [31:0] RESULT;
  logic [4:0]  WRITE_ADDR_OUT;
  logic        DONE;
  logic        BUSY;
  logic        STALL;
  state_t      DBG_STATE;

  modport master (
    output START, FUNC3, OPERAND_A, OPERAND_B, WRITE_ADDR_IN, FLUSH,
    input  RESULT, WRITE_ADDR_OUT, DONE, BUSY, STALL, DBG_STATE
  );

  modport slave (
    input  START, FUNC3, OPERAND_A, OPERAND_B, WRITE_ADDR_IN, FLUSH,
    output RESULT, WRITE_ADDR_OUT, DONE, BUSY, STALL, DBG_STATE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on operand magnitudes,
// sign fix-up on entry to FINISH; divide-by-zero and signed overflow bypass CALC.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input logic          CLK,
  input logic          RST,
  muldiv_unit_if.slave bus
);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_func3;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_waddr;
  logic [31:0] r_result;
  logic [4:0]  r_waddr_out;
  logic        r_done;

  logic        w_is_div;
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_special;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_hi_n;
  logic [31:0] w_lo_n;

  assign w_is_div = bus.FUNC3[2];
  assign w_sgn_a  = (bus.FUNC3 != F3_MULHU) && (bus.FUNC3 != F3_DIVU) &&
                    (bus.FUNC3 != F3_REMU);
  assign w_sgn_b  = (bus.FUNC3 == F3_MUL) || (bus.FUNC3 == F3_MULH) ||
                    (bus.FUNC3 == F3_DIV) || (bus.FUNC3 == F3_REM);
  assign w_neg_a  = w_sgn_a & bus.OPERAND_A[31];
  assign w_neg_b  = w_sgn_b & bus.OPERAND_B[31];
  assign w_mag_a  = w_neg_a ? -bus.OPERAND_A : bus.OPERAND_A;
  assign w_mag_b  = w_neg_b ? -bus.OPERAND_B : bus.OPERAND_B;

  // Only signed DIV/REM (FUNC3[0]=0) can overflow.
  assign w_div_zero = w_is_div && (bus.OPERAND_B == 32'h0);
  assign w_div_ovf  = w_is_div && !bus.FUNC3[0] &&
                      (bus.OPERAND_A == 32'h8000_0000) &&
                      (bus.OPERAND_B == 32'hFFFF_FFFF);

  always_comb begin
    w_special = 32'h0;
    if (w_div_zero) w_special = bus.FUNC3[1] ? bus.OPERAND_A : 32'hFFFF_FFFF;
    else            w_special = bus.FUNC3[1] ? 32'h0 : 32'h8000_0000;
  end

  // Multiply: {hi,lo} shifts right with the multiplier consumed from lo[0].
  // Divide: remainder in hi, dividend shifts out of lo while quotient bits shift in.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_op});
  assign w_diff  = w_shift[31:0] - r_op;

  always_comb begin
    w_hi_n = w_sum[32:1];
    w_lo_n = {w_sum[0], r_lo[31:1]};
    if (r_func3[2]) begin
      w_hi_n = w_ge ? w_diff : w_shift[31:0];
      w_lo_n = {r_lo[30:0], w_ge};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_func3     <= 3'd0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_op        <= 32'h0;
      r_hi        <= 32'h0;
      r_lo        <= 32'h0;
      r_waddr     <= 5'd0;
      r_result    <= 32'h0;
      r_waddr_out <= 5'd0;
      r_done      <= 1'b0;
    end else if (bus.FLUSH) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.START) begin
            r_func3 <= bus.FUNC3;
            r_waddr <= bus.WRITE_ADDR_IN;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            if (w_div_zero || w_div_ovf) begin
              r_result    <= w_special;
              r_waddr_out <= bus.WRITE_ADDR_IN;
              r_done      <= 1'b1;
              r_state     <= S_FINISH;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_hi    <= 32'h0;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_op    <= w_is_div ? w_mag_b : w_mag_a;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi <= w_hi_n;
          r_lo <= w_lo_n;
          if (r_cnt == 5'd0) begin
            r_result    <= mdu_finalize(r_func3, r_neg_a, r_neg_b, w_hi_n, w_lo_n);
            r_waddr_out <= r_waddr;
            r_done      <= 1'b1;
            r_state     <= S_FINISH;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RESULT         = r_result;
  assign bus.WRITE_ADDR_OUT = r_waddr_out;
  assign bus.DONE           = r_done;
  assign bus.BUSY           = (r_state == S_CALC) || (r_state == S_FINISH);
  assign bus.STALL          = RST && (((r_state == S_IDLE) && bus.START) ||
                                      (r_state == S_CALC));
  assign bus.DBG_STATE      = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver tasks push expected {waddr,result} and
// DONE cycle; a negedge monitor pops and compares on every DONE pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic CLK;
  logic RST;
  muldiv_unit_if bus ();

  muldiv_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [36:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc;
  int          stall_cnt;
  int          n_checks;
  int          n_errors;
  logic [31:0] last_res;

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (bus.STALL) stall_cnt++;
    if (bus.DONE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [36:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("result", {32'h0, bus.RESULT}, {32'h0, e[31:0]});
        chk("waddr", {59'h0, bus.WRITE_ADDR_OUT}, {59'h0, e[36:32]});
        chk("done_cycle", 64'(cyc), 64'(ec));
        chk("busy_in_finish", {63'h0, bus.BUSY}, 64'd1);
        chk("stall_in_finish", {63'h0, bus.STALL}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    @(posedge CLK);
    #1;
    bus.START         = 1'b1;
    bus.FUNC3         = f3;
    bus.OPERAND_A     = a;
    bus.OPERAND_B     = b;
    bus.WRITE_ADDR_IN = wa;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DBG_STATE == S_IDLE) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp, input int lat);
    drive(f3, a, b, wa);
    exp_q.push_back({wa, exp});
    exp_cyc_q.push_back(cyc + lat);
    last_res = exp;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    wait_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    stall_cnt = 0;
    cyc = 0;
    last_res = 32'h0;
    bus.START = 1'b0;
    bus.FUNC3 = 3'd0;
    bus.OPERAND_A = 32'h0;
    bus.OPERAND_B = 32'h0;
    bus.WRITE_ADDR_IN = 5'd0;
    bus.FLUSH = 1'b0;
    RST = 1'b0;
    #12;
    bus.START = 1'b1;
    #1;
    chk("rst_result", {32'h0, bus.RESULT}, 64'd0);
    chk("rst_waddr", {59'h0, bus.WRITE_ADDR_OUT}, 64'd0);
    chk("rst_done", {63'h0, bus.DONE}, 64'd0);
    chk("rst_busy", {63'h0, bus.BUSY}, 64'd0);
    chk("rst_stall", {63'h0, bus.STALL}, 64'd0);
    bus.START = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // multiply, with 33-cycle STALL window and RESULT hold after DONE
    stall_cnt = 0;
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
    chk("stall_cycles", 64'(stall_cnt), 64'd33);
    repeat (3) @(posedge CLK);
    #1;
    chk("result_hold", {32'h0, bus.RESULT}, {32'h0, last_res});
    issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    issue(F3_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33);
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
    issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33);
    issue(F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd6,  32'h2345_6780, 33);

    // divide special cases (no CALC)
    issue(F3_DIV,  32'h0000_0064, 32'h0, 5'd7,  32'hFFFF_FFFF, 1);
    issue(F3_REM,  32'h0000_0064, 32'h0, 5'd8,  32'h0000_0064, 1);
    issue(F3_DIVU, 32'h0000_0064, 32'h0, 5'd9,  32'hFFFF_FFFF, 1);
    issue(F3_REMU, 32'h0000_0007, 32'h0, 5'd10, 32'h0000_0007, 1);
    issue(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    issue(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1);

    // normal divide
    issue(F3_REMU, 32'd100,       32'd7, 5'd13, 32'h0000_0002, 33);
    issue(F3_REM,  32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFFE, 33);
    issue(F3_DIV,  32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFF2, 33);
    issue(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 33);

    // FLUSH at CALC cycle 10
    drive(F3_MUL, 32'd3, 32'd5, 5'd17);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    bus.FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    bus.FLUSH = 1'b0;
    chk("flush_idle", {62'h0, bus.DBG_STATE}, {62'h0, S_IDLE});
    chk("flush_stall", {63'h0, bus.STALL}, 64'd0);
    chk("flush_busy", {63'h0, bus.BUSY}, 64'd0);
    repeat (40) @(posedge CLK);

    // FLUSH with START in IDLE: nothing starts
    drive(F3_MUL, 32'd3, 32'd5, 5'd18);
    bus.FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    chk("flush_start_idle", {62'h0, bus.DBG_STATE}, {62'h0, S_IDLE});

    // reset at CALC cycle 20, START held high during reset
    drive(F3_DIVU, 32'd1000, 32'd3, 5'd19);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.START = 1'b1;
    #1;
    chk("rst_mid_idle", {62'h0, bus.DBG_STATE}, {62'h0, S_IDLE});
    chk("rst_mid_stall", {63'h0, bus.STALL}, 64'd0);
    chk("rst_mid_result", {32'h0, bus.RESULT}, 64'd0);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    RST = 1'b1;
    repeat (40) @(posedge CLK);
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd20, 32'd333, 33);

    // START while BUSY is ignored
    drive(F3_MUL, 32'd6, 32'd7, 5'd21);
    exp_q.push_back({5'd21, 32'd42});
    exp_cyc_q.push_back(cyc + 33);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    bus.START = 1'b1;
    bus.FUNC3 = F3_DIV;
    bus.OPERAND_A = 32'd99;
    bus.OPERAND_B = 32'd0;
    bus.WRITE_ADDR_IN = 5'd22;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    wait_idle();
    repeat (40) @(posedge CLK);
    #1;
    chk("busy_start_result", {32'h0, bus.RESULT}, 64'd42);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
